// File: rtl/microwave_ctrl.sv
// microwave_ctrl: front-panel controller for a BCD countdown timer, magnetron and beeper.
// Optional feature macro: MICROWAVE_QUICK_START_EN (start with timer at 0:00 loads 0:30 and cooks).
// Ports:
//   i_clock        system clock, rising edge
//   i_clrn         synchronous active-low reset
//   i_key[9:0]     digit keys 0..9, active-high, one-hot press
//   i_startn       start/resume button, active-low
//   i_stopn        stop/cancel button, active-low
//   i_door_closed  1 = door closed
//   i_timer_zero   timer reads 0:00
//   o_timer_data   BCD digit presented with o_timer_loadn
//   o_timer_loadn  1-cycle active-low shift-load strobe
//   o_timer_en     1-cycle active-high decrement strobe
//   o_timer_clrn   1-cycle active-low clear strobe
//   o_magnet_on    magnetron drive
//   o_beep         beeper drive
//   o_state        IDLE=0 COOKING=1 PAUSED=2 DONE=3
module microwave_ctrl #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int BEEP_SECS   = 3
) (
  input  logic       i_clock,
  input  logic       i_clrn,
  input  logic [9:0] i_key,
  input  logic       i_startn,
  input  logic       i_stopn,
  input  logic       i_door_closed,
  input  logic       i_timer_zero,
  output logic [3:0] o_timer_data,
  output logic       o_timer_loadn,
  output logic       o_timer_en,
  output logic       o_timer_clrn,
  output logic       o_magnet_on,
  output logic       o_beep,
  output logic [1:0] o_state
);
  localparam int BEEP_CYC = BEEP_SECS * CLK_PER_SEC;
  localparam int CW = $clog2(BEEP_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, COOKING = 2'd1, PAUSED = 2'd2, DONE = 2'd3;
`ifdef MICROWAVE_QUICK_START_EN
  localparam logic QS_EN = 1'b1;
`else
  localparam logic QS_EN = 1'b0;
`endif
  logic [9:0]    r_key, r_key_d;
  logic          r_start, r_start_d, r_stop, r_stop_d;
  logic [1:0]    r_state, r_qs;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_timer_data;
  logic          r_timer_loadn, r_timer_en, r_timer_clrn, r_magnet_on, r_beep;
  logic          w_key_evt, w_start_evt, w_stop_evt, w_tick, w_qs_abort, w_qs_go, w_qs_load0, w_digit_ld;
  logic [3:0]    w_digit, w_data_nx;
  logic [1:0]    w_state_nx, w_qs_nx;
  logic          w_loadn_nx, w_en_nx, w_clrn_nx;
  // a digit press is a one-hot key pattern appearing from all-released
  assign w_key_evt   = (r_key != '0) && ((r_key & (r_key - 10'd1)) == '0) && (r_key_d == '0);
  assign w_start_evt = r_start & ~r_start_d;
  assign w_stop_evt  = r_stop & ~r_stop_d;
  assign w_tick      = r_cnt == CW'(CLK_PER_SEC - 1);
  assign w_qs_abort  = !i_door_closed || w_stop_evt;
  // quick-start phases: 1 = data 3 issued, 2 = gap cycle, 3 = data 0 issued, then COOKING
  assign w_qs_go     = (r_qs == 2'd0) && (w_qs_nx == 2'd1);
  assign w_qs_load0  = (r_qs == 2'd2) && !w_qs_abort;
  assign w_digit_ld  = (r_state == IDLE) && (r_qs == 2'd0) && w_key_evt;
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < 10; i++)
      if (r_key[i]) w_digit = 4'(i);
  end
  always_ff @(posedge i_clock) begin
    if (!i_clrn) begin
      r_key <= '0;
      r_key_d <= '0;
      r_start <= 1'b0;
      r_start_d <= 1'b0;
      r_stop <= 1'b0;
      r_stop_d <= 1'b0;
      r_state <= IDLE;
      r_qs <= '0;
      r_cnt <= '0;
    end else begin
      r_key <= i_key;
      r_key_d <= r_key;
      r_start <= ~i_startn;
      r_start_d <= r_start;
      r_stop <= ~i_stopn;
      r_stop_d <= r_stop;
      r_state <= w_state_nx;
      r_qs <= w_qs_nx;
      // one counter serves as prescaler in COOKING and beep timer in DONE; held in PAUSED
      r_cnt <= (w_state_nx != r_state) ? '0 : (r_state == COOKING && w_tick) ? '0 :
               r_state[0] ? r_cnt + CW'(1) : r_cnt;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_qs_nx = r_qs;
    case (r_state)
      IDLE:
        if (r_qs != 2'd0) begin
          w_qs_nx = w_qs_abort ? 2'd0 : r_qs + 2'd1;
          w_state_nx = (r_qs == 2'd3 && !w_qs_abort) ? COOKING : IDLE;
        end else if (w_start_evt && i_door_closed) begin
          if (!i_timer_zero) w_state_nx = COOKING;
          else if (QS_EN) w_qs_nx = 2'd1;
        end
      COOKING: w_state_nx = (!i_door_closed || w_stop_evt) ? PAUSED : i_timer_zero ? DONE : COOKING;
      PAUSED:  w_state_nx = w_stop_evt ? IDLE :
                            (w_start_evt && i_door_closed) ? (i_timer_zero ? DONE : COOKING) : PAUSED;
      DONE:    w_state_nx = (w_key_evt || w_start_evt || w_stop_evt || !i_door_closed ||
                             r_cnt == CW'(BEEP_CYC - 1)) ? IDLE : DONE;
    endcase
  end
  always_comb begin
    w_loadn_nx = !(w_digit_ld || w_qs_go || w_qs_load0);
    w_data_nx  = w_qs_go ? 4'd3 : w_qs_load0 ? 4'd0 : w_digit_ld ? w_digit : r_timer_data;
    // a tick coinciding with any exit (incl. timer at zero) is dropped to avoid a 0:00 wrap
    w_en_nx    = (r_state == COOKING) && (w_state_nx == COOKING) && w_tick;
    w_clrn_nx  = !(w_stop_evt && (((r_state == IDLE) && (r_qs == 2'd0)) || (r_state == PAUSED)));
  end
  always_ff @(posedge i_clock) begin
    if (!i_clrn) begin
      r_timer_data <= '0;
      r_timer_loadn <= 1'b1;
      r_timer_en <= 1'b0;
      r_timer_clrn <= 1'b0;
      r_magnet_on <= 1'b0;
      r_beep <= 1'b0;
    end else begin
      r_timer_data <= w_data_nx;
      r_timer_loadn <= w_loadn_nx;
      r_timer_en <= w_en_nx;
      r_timer_clrn <= w_clrn_nx;
      r_magnet_on <= w_state_nx == COOKING;
      r_beep <= w_state_nx == DONE;
    end
  end
  assign o_timer_data  = r_timer_data;
  assign o_timer_loadn = r_timer_loadn;
  assign o_timer_en    = r_timer_en;
  assign o_timer_clrn  = r_timer_clrn;
  assign o_magnet_on   = r_magnet_on;
  assign o_beep        = r_beep;
  assign o_state       = r_state;
endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed scoreboard bench for microwave_ctrl with CLK_PER_SEC=4, BEEP_SECS=3.
module tb_microwave_ctrl;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] key = '0;
  logic       startn = 1'b1, stopn = 1'b1, door = 1'b1, tz = 1'b0;
  logic [3:0] data;
  logic       loadn, en, tclrn, magnet, beep;
  logic [1:0] state;
  int nvec = 0, nerr = 0, n_load = 0, n_en = 0, n_clr = 0;
  int e0, c0, l0;
  logic [3:0] exp_q[$];
  logic [3:0] digs[3] = '{4'd1, 4'd3, 4'd0};
  microwave_ctrl #(.CLK_PER_SEC(4), .BEEP_SECS(3)) dut (
    .i_clock(clk), .i_clrn(clrn), .i_key(key), .i_startn(startn), .i_stopn(stopn),
    .i_door_closed(door), .i_timer_zero(tz), .o_timer_data(data), .o_timer_loadn(loadn),
    .o_timer_en(en), .o_timer_clrn(tclrn), .o_magnet_on(magnet), .o_beep(beep), .o_state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_start();
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
    tick(1);
  endtask
  task automatic press_stop();
    stopn = 1'b0;
    tick(1);
    stopn = 1'b1;
    tick(1);
  endtask
  always @(negedge clk) begin
    if (clrn && !loadn) begin
      n_load++;
      chk("load_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("load_data", data, exp_q.pop_front());
    end
    if (en) n_en++;
    if (!tclrn) n_clr++;
  end
  initial begin
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_loadn", loadn, 1);
    chk("rst_en", en, 0);
    chk("rst_clrn", tclrn, 0);
    chk("rst_magnet", magnet, 0);
    chk("rst_beep", beep, 0);
    chk("rst_data", data, 0);
    clrn = 1'b1;
    tick(1);
    chk("clrn_release", tclrn, 1);
    // digit entry
    for (int i = 0; i < 3; i++) begin
      key = 10'b1 << digs[i];
      exp_q.push_back(digs[i]);
      tick(2);
      chk("key_strobe", loadn, 0);
      tick(1);
      chk("key_strobe_end", loadn, 1);
      tick(7);
      key = '0;
      tick(5);
    end
    key = 10'b1 << 5;
    exp_q.push_back(4'd5);
    tick(100);
    key = '0;
    tick(5);
    key = 10'b0000000011;
    tick(10);
    key = '0;
    tick(5);
    chk("load_count", n_load, 4);
    chk("load_q_empty", exp_q.size(), 0);
    // cooking ticks
    press_start();
    chk("cook_state", state, 1);
    chk("cook_magnet", magnet, 1);
    tick(3);
    chk("en_k3", en, 0);
    tick(1);
    chk("en_k4", en, 1);
    tick(1);
    chk("en_k5", en, 0);
    tick(3);
    chk("en_k8", en, 1);
    tick(4);
    chk("en_k12", en, 1);
    // door open -> pause -> resume -> stop -> stop
    tick(2);
    door = 1'b0;
    tick(1);
    chk("door_pause", state, 2);
    chk("door_magnet", magnet, 0);
    e0 = n_en;
    tick(8);
    chk("pause_no_en", n_en, e0);
    door = 1'b1;
    press_start();
    chk("resume_state", state, 1);
    tick(3);
    chk("resume_en3", en, 0);
    tick(1);
    chk("resume_en4", en, 1);
    press_stop();
    chk("stop_pause", state, 2);
    c0 = n_clr;
    press_stop();
    chk("stop_idle", state, 0);
    chk("stop_clr", tclrn, 0);
    tick(1);
    chk("stop_clr_end", tclrn, 1);
    chk("clr_count", n_clr, c0 + 1);
    // zero on the tick cycle -> DONE, full beep
    e0 = n_en;
    press_start();
    tick(3);
    tz = 1'b1;
    tick(1);
    chk("done_state", state, 3);
    chk("done_beep", beep, 1);
    chk("done_no_en", n_en, e0);
    tick(11);
    chk("beep_last", beep, 1);
    tick(1);
    chk("beep_off", beep, 0);
    chk("done_idle", state, 0);
    // DONE cut short by a key
    tz = 1'b0;
    press_start();
    tz = 1'b1;
    tick(1);
    chk("done2_state", state, 3);
    tz = 1'b0;
    tick(3);
    l0 = n_load;
    key = 10'b1 << 7;
    tick(1);
    key = '0;
    tick(1);
    chk("key_ends_done", state, 0);
    chk("key_ends_beep", beep, 0);
    tick(3);
    chk("key_no_load", n_load, l0);
    // start with timer at zero
    tz = 1'b1;
    l0 = n_load;
`ifdef MICROWAVE_QUICK_START_EN
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
    tick(3);
    tz = 1'b0;
    tick(1);
    chk("qs_state", state, 1);
    chk("qs_loads", n_load, l0 + 2);
    press_stop();
    press_stop();
`else
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
    tick(4);
    chk("zero_start_state", state, 0);
    chk("zero_start_loads", n_load, l0);
    tz = 1'b0;
`endif
    chk("qs_q_empty", exp_q.size(), 0);
    // reset mid-second
    press_start();
    chk("pre_rst_state", state, 1);
    tick(6);
    clrn = 1'b0;
    tick(1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_magnet", magnet, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_loadn", loadn, 1);
    chk("mid_rst_clrn", tclrn, 0);
    chk("mid_rst_data", data, 0);
    clrn = 1'b1;
    tick(1);
    press_start();
    chk("restart_state", state, 1);
    tick(3);
    chk("restart_en3", en, 0);
    tick(1);
    chk("restart_en4", en, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
